// File: rtl/downsample_top_processor.sv
// -----------------------------------------------------------------------------
// downsample_top_processor
//
// Receives an IMG_W x IMG_W 8-bit grayscale image over UART (8N1, LSB first),
// reduces it 2:1 in both axes and streams the (IMG_W/2)^2 result bytes back
// over UART.  Contains the UART receiver, UART transmitter, image RAM, result
// RAM and the phase-control FSM.
//
// Build option:
//   DOWNSAMPLE_AVG_EN  defined   -> output = rounded mean of the 2x2 block
//                      undefined -> output = top-left pixel of the 2x2 block
//
// Ports:
//   clock            system clock, rising edge
//   rst_n            synchronous active-low reset
//   data_from_pc     from IDLE, high starts image reception
//   start_process    in RX_DONE, high starts down-sampling
//   start_transmit   in PROC_DONE, high starts result transmission
//   rx               UART serial input (idle high)
//   rd_clr           clears rd_rx
//   rd_rx            sticky "byte received" flag
//   tx               UART serial output (idle high)
//   tx_busy          transmitter shifting a frame
//   LEDR[7:0]        last byte received
//   endImagereceived high in RX_DONE and later states
//   endProcess       high in PROC_DONE and later states
//   data_to_pc       high in TX_DONE
//   g1, g2, g3       RECEIVE / PROCESS / TRANSMIT phase lamps
//   s00..s03         FSM state code bits 0..3
//   clk              heartbeat, toggles every clock
//   s0               high while FSM is IDLE
// -----------------------------------------------------------------------------
module downsample_top_processor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int IMG_W        = 8
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       data_from_pc,
  input  logic       start_process,
  input  logic       start_transmit,
  input  logic       rx,
  input  logic       rd_clr,
  output logic       rd_rx,
  output logic       tx,
  output logic       tx_busy,
  output logic [7:0] LEDR,
  output logic       endImagereceived,
  output logic       endProcess,
  output logic       data_to_pc,
  output logic       g1,
  output logic       g2,
  output logic       g3,
  output logic       s00,
  output logic       s01,
  output logic       s02,
  output logic       s03,
  output logic       clk,
  output logic       s0
);

  localparam int NPIX = IMG_W * IMG_W;
  localparam int NOUT = NPIX / 4;
  localparam int AW   = $clog2(NPIX);
  localparam int OW   = $clog2(NOUT);
  localparam int HW   = IMG_W / 2;
  localparam int CW   = $clog2(HW);
  localparam int CNTW = $clog2(CLKS_PER_BIT + 1);

  localparam logic [AW-1:0]   LAST_PIX = AW'(NPIX - 1);
  localparam logic [AW-1:0]   ONE_A    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [OW:0]     NOUT_T   = (OW+1)'(NOUT);
  localparam logic [OW:0]     ONE_T    = {{OW{1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HALF_CNT = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] ONE_C    = {{(CNTW-1){1'b0}}, 1'b1};

  // Control FSM codes (visible on s00..s03)
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_RECEIVE   = 4'd1;
  localparam logic [3:0] ST_RX_DONE   = 4'd2;
  localparam logic [3:0] ST_PROCESS   = 4'd3;
  localparam logic [3:0] ST_PROC_DONE = 4'd4;
  localparam logic [3:0] ST_TRANSMIT  = 4'd5;
  localparam logic [3:0] ST_TX_DONE   = 4'd6;

  // UART receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

`ifdef DOWNSAMPLE_AVG_EN
  // Rounded mean of four pixels; a 10-bit sum of four bytes cannot overflow.
  function automatic logic [7:0] round_avg4(input logic [9:0] sum);
    logic [9:0] rounded;
    rounded = sum + 10'd2;
    return rounded[9:2];
  endfunction
`endif

  logic [3:0]      state;
  logic [AW-1:0]   pix_addr;
  logic [AW-1:0]   proc_cnt;
  logic [OW:0]     tx_sent;
  logic [7:0]      img_mem [NPIX];
  logic [7:0]      res_mem [NOUT];

  logic            rx_q1, rx_q2, rx_q3;
  logic [1:0]      rx_state;
  logic [CNTW-1:0] rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_valid;
  logic [7:0]      rx_byte;

  logic [CNTW-1:0] tx_cnt;
  logic [3:0]      tx_bit;
  logic [8:0]      tx_shift;
  logic            tx_go;
  logic [7:0]      tx_data;

  logic [AW-1:0]   rd_addr;
  logic [7:0]      pixel;
  logic [7:0]      res_value;
`ifdef DOWNSAMPLE_AVG_EN
  logic [9:0]      acc;
`else
  logic [7:0]      acc;
`endif

  // Double-flop the asynchronous serial input; rx_q3 is the previous sample
  // used for falling-edge detection.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rx_q1 <= 1'b1;
      rx_q2 <= 1'b1;
      rx_q3 <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_q2 <= rx_q1;
      rx_q3 <= rx_q2;
    end
  end

  // UART receiver: start validated at mid-bit, data and stop sampled mid-bit.
  // rx_valid pulses for one cycle with rx_byte only when the stop bit is 1.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_valid <= 1'b0;
      rx_byte  <= 8'h00;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= 3'd0;
          if (rx_q3 && !rx_q2) begin
            rx_state <= RX_START;
          end else begin
            rx_state <= RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_CNT) begin
            rx_cnt   <= '0;
            rx_state <= rx_q2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + ONE_C;
          end
        end
        RX_DATA: begin
          if (rx_cnt == LAST_CNT) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_q2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + ONE_C;
          end
        end
        RX_STOP: begin
          if (rx_cnt == LAST_CNT) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_q2) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end else begin
              rx_valid <= 1'b0;
            end
          end else begin
            rx_cnt <= rx_cnt + ONE_C;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Received-byte display and sticky flag; a new byte beats a clear.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      LEDR  <= 8'h00;
      rd_rx <= 1'b0;
    end else if (rx_valid) begin
      LEDR  <= rx_byte;
      rd_rx <= 1'b1;
    end else if (rd_clr) begin
      rd_rx <= 1'b0;
    end else begin
      rd_rx <= rd_rx;
    end
  end

  // Block read address for the current down-sampling step: proc_cnt holds
  // {out_row, out_col, dy, dx}, so the pixel is ((2r+dy), (2c+dx)).
  always_comb begin
    rd_addr = {proc_cnt[AW-1:AW-CW], proc_cnt[1], proc_cnt[CW+1:2], proc_cnt[0]};
    pixel   = img_mem[rd_addr];
    tx_data = res_mem[tx_sent[OW-1:0]];
    tx_go   = 1'b0;
    if (state == ST_TRANSMIT && !tx_busy && tx_sent != NOUT_T) begin
      tx_go = 1'b1;
    end else begin
      tx_go = 1'b0;
    end
`ifdef DOWNSAMPLE_AVG_EN
    res_value = round_avg4(acc + {2'b00, pixel});
`else
    res_value = acc;
`endif
  end

  // UART transmitter: start bit, 8 data bits, stop bit, CLKS_PER_BIT each.
  // tx_busy drops in the cycle after the last stop-bit cycle.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_shift <= 9'h1FF;
    end else if (!tx_busy) begin
      tx <= 1'b1;
      if (tx_go) begin
        tx_busy  <= 1'b1;
        tx       <= 1'b0;
        tx_shift <= {1'b1, tx_data};
        tx_cnt   <= '0;
        tx_bit   <= 4'd0;
      end else begin
        tx_busy <= 1'b0;
      end
    end else if (tx_cnt == LAST_CNT) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        tx      <= 1'b1;
      end else begin
        tx       <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bit   <= tx_bit + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + ONE_C;
    end
  end

  // Phase-control FSM with pixel, process and transmit counters.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pix_addr <= '0;
      proc_cnt <= '0;
      tx_sent  <= '0;
      acc      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_from_pc) begin
            state    <= ST_RECEIVE;
            pix_addr <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RECEIVE: begin
          if (rx_valid) begin
            pix_addr <= pix_addr + ONE_A;
            if (pix_addr == LAST_PIX) begin
              state <= ST_RX_DONE;
            end else begin
              state <= ST_RECEIVE;
            end
          end else begin
            state <= ST_RECEIVE;
          end
        end
        ST_RX_DONE: begin
          if (start_process) begin
            state    <= ST_PROCESS;
            proc_cnt <= '0;
          end else begin
            state <= ST_RX_DONE;
          end
        end
        ST_PROCESS: begin
          proc_cnt <= proc_cnt + ONE_A;
`ifdef DOWNSAMPLE_AVG_EN
          acc <= (proc_cnt[1:0] == 2'b00) ? {2'b00, pixel} : acc + {2'b00, pixel};
`else
          // Only the first (top-left) read of each block is kept.
          if (proc_cnt[1:0] == 2'b00) begin
            acc <= pixel;
          end else begin
            acc <= acc;
          end
`endif
          if (proc_cnt == LAST_PIX) begin
            state <= ST_PROC_DONE;
          end else begin
            state <= ST_PROCESS;
          end
        end
        ST_PROC_DONE: begin
          if (start_transmit) begin
            state   <= ST_TRANSMIT;
            tx_sent <= '0;
          end else begin
            state <= ST_PROC_DONE;
          end
        end
        ST_TRANSMIT: begin
          if (tx_go) begin
            tx_sent <= tx_sent + ONE_T;
          end else if (tx_sent == NOUT_T && !tx_busy) begin
            state <= ST_TX_DONE;
          end else begin
            state <= ST_TRANSMIT;
          end
        end
        ST_TX_DONE: begin
          if (!data_from_pc && !start_process && !start_transmit) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_TX_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Image and result RAMs; contents survive reset.
  always_ff @(posedge clock) begin
    if (rst_n && state == ST_RECEIVE && rx_valid) begin
      img_mem[pix_addr] <= rx_byte;
    end
    if (rst_n && state == ST_PROCESS && proc_cnt[1:0] == 2'b11) begin
      res_mem[proc_cnt[AW-1:2]] <= res_value;
    end
  end

  // Registered status, phase lamps, state code and heartbeat.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      endImagereceived <= 1'b0;
      endProcess       <= 1'b0;
      data_to_pc       <= 1'b0;
      g1               <= 1'b0;
      g2               <= 1'b0;
      g3               <= 1'b0;
      s00              <= 1'b0;
      s01              <= 1'b0;
      s02              <= 1'b0;
      s03              <= 1'b0;
      s0               <= 1'b1;
      clk              <= 1'b0;
    end else begin
      endImagereceived <= (state >= ST_RX_DONE);
      endProcess       <= (state >= ST_PROC_DONE);
      data_to_pc       <= (state == ST_TX_DONE);
      g1               <= (state == ST_RECEIVE);
      g2               <= (state == ST_PROCESS);
      g3               <= (state == ST_TRANSMIT);
      s00              <= state[0];
      s01              <= state[1];
      s02              <= state[2];
      s03              <= state[3];
      s0               <= (state == ST_IDLE);
      clk              <= ~clk;
    end
  end

endmodule

// File: tb/tb_downsample_top_processor.sv
module tb_downsample_top_processor;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_from_pc = 1'b0;
  logic       start_process = 1'b0;
  logic       start_transmit = 1'b0;
  logic       rx = 1'b1;
  logic       rd_clr = 1'b0;
  logic       rd_rx, tx, tx_busy;
  logic [7:0] LEDR;
  logic       endImagereceived, endProcess, data_to_pc;
  logic       g1, g2, g3, s00, s01, s02, s03, clk, s0;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q [$];
  int         pix [64];

  downsample_top_processor #(.CLKS_PER_BIT(CPB), .IMG_W(8)) dut (
    .clock(clock), .rst_n(rst_n), .data_from_pc(data_from_pc),
    .start_process(start_process), .start_transmit(start_transmit),
    .rx(rx), .rd_clr(rd_clr), .rd_rx(rd_rx), .tx(tx), .tx_busy(tx_busy),
    .LEDR(LEDR), .endImagereceived(endImagereceived), .endProcess(endProcess),
    .data_to_pc(data_to_pc), .g1(g1), .g2(g2), .g3(g3),
    .s00(s00), .s01(s01), .s02(s02), .s03(s03), .clk(clk), .s0(s0)
  );

  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] code();
    return {s03, s02, s01, s00};
  endfunction

  // Reference result for output o of the current image model.
  function automatic logic [7:0] exp_out(input int o);
    int r, c, a, b, d, e;
    r = o / 4;
    c = o % 4;
    a = pix[(2*r)*8 + 2*c];
    b = pix[(2*r)*8 + 2*c + 1];
    d = pix[(2*r+1)*8 + 2*c];
    e = pix[(2*r+1)*8 + 2*c + 1];
`ifdef DOWNSAMPLE_AVG_EN
    return 8'((a + b + d + e + 2) / 4);
`else
    return 8'(a);
`endif
  endfunction

  task automatic uart_send(input logic [7:0] b, input logic stop);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Decode one frame from tx; reports busy at the last frame cycle and the next.
  task automatic tx_frame(output logic [7:0] b, output logic got, output logic stop_ok,
                          output logic busy_end, output logic busy_after);
    got = 1'b0; b = 8'h00; stop_ok = 1'b0; busy_end = 1'b0; busy_after = 1'b1;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clock);
      if (tx === 1'b0) got = 1'b1;
    end
    if (got) begin
      repeat (8) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clock);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clock);
      stop_ok = (tx === 1'b1);
      repeat (7) @(negedge clock);
      busy_end = tx_busy;
      @(negedge clock);
      busy_after = tx_busy;
    end
  endtask

  task automatic test_reset();
    logic c1;
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    n_checks++; if (rd_rx !== 1'b0) begin n_fail++; $display("FAIL reset_rd_rx: got %b want 0", rd_rx); end
    n_checks++; if (LEDR !== 8'h00) begin n_fail++; $display("FAIL reset_LEDR: got %h want 00", LEDR); end
    n_checks++; if (code() !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", code()); end
    n_checks++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL reset_s0: got %b want 1", s0); end
    n_checks++; if (clk !== 1'b0) begin n_fail++; $display("FAIL reset_clk: got %b want 0", clk); end
    n_checks++;
    if ({g1, g2, g3, endImagereceived, endProcess, data_to_pc} !== 6'b0) begin
      n_fail++; $display("FAIL reset_lamps: got %b want 000000",
                         {g1, g2, g3, endImagereceived, endProcess, data_to_pc});
    end
    rst_n = 1'b1;
    @(negedge clock);
    c1 = clk;
    @(negedge clock);
    n_checks++; if (clk !== ~c1) begin n_fail++; $display("FAIL heartbeat: got %b want %b", clk, ~c1); end
  endtask

  task automatic test_uart_rx();
    logic [7:0] e;
    int t;
    exp_q.push_back(8'hA5);
    uart_send(8'hA5, 1'b1);
    t = 0;
    while (rd_rx !== 1'b1 && t < 100) begin @(negedge clock); t++; end
    e = exp_q.pop_front();
    n_checks++; if (LEDR !== e) begin n_fail++; $display("FAIL rx_byte: got %h want %h", LEDR, e); end
    n_checks++; if (rd_rx !== 1'b1) begin n_fail++; $display("FAIL rx_flag: got %b want 1", rd_rx); end
    @(negedge clock); rd_clr = 1'b1;
    @(negedge clock); rd_clr = 1'b0;
    n_checks++; if (rd_rx !== 1'b0) begin n_fail++; $display("FAIL rd_clr: got %b want 0", rd_rx); end
    uart_send(8'h3C, 1'b0);
    repeat (20) @(negedge clock);
    n_checks++; if (LEDR !== 8'hA5) begin n_fail++; $display("FAIL bad_stop_LEDR: got %h want a5", LEDR); end
    n_checks++; if (rd_rx !== 1'b0) begin n_fail++; $display("FAIL bad_stop_flag: got %b want 0", rd_rx); end
  endtask

  // Receive the image in pix[], process it, then transmit; abort with reset
  // during the second frame when abort_tx is set.
  task automatic test_flow(input string tag, input bit abort_tx);
    int t, cnt;
    logic [7:0] b, e;
    logic got, stop_ok, be, ba;
    @(negedge clock); data_from_pc = 1'b1;
    @(negedge clock); data_from_pc = 1'b0;
    @(negedge clock);
    n_checks++; if (code() !== 4'd1 || g1 !== 1'b1) begin
      n_fail++; $display("FAIL %s_receive_state: got code %0d g1 %b want 1 1", tag, code(), g1);
    end
    for (int i = 0; i < 64; i++) uart_send(8'(pix[i]), 1'b1);
    t = 0;
    while (endImagereceived !== 1'b1 && t < 200) begin @(negedge clock); t++; end
    n_checks++; if (endImagereceived !== 1'b1 || code() !== 4'd2) begin
      n_fail++; $display("FAIL %s_rx_done: got end %b code %0d want 1 2", tag, endImagereceived, code());
    end
    @(negedge clock); start_process = 1'b1;
    t = 0;
    while (g2 !== 1'b1 && t < 20) begin @(negedge clock); t++; end
    cnt = 0;
    while (g2 === 1'b1 && cnt < 200) begin @(negedge clock); cnt++; end
    start_process = 1'b0;
    n_checks++; if (cnt != 64) begin n_fail++; $display("FAIL %s_process_cycles: got %0d want 64", tag, cnt); end
    n_checks++; if (endProcess !== 1'b1 || code() !== 4'd4) begin
      n_fail++; $display("FAIL %s_proc_done: got end %b code %0d want 1 4", tag, endProcess, code());
    end
    for (int o = 0; o < 16; o++) exp_q.push_back(exp_out(o));
    @(negedge clock); start_transmit = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tx_frame(b, got, stop_ok, be, ba);
      e = exp_q.pop_front();
      n_checks++; if (!got) begin n_fail++; $display("FAIL %s_tx_timeout byte %0d: got none want %h", tag, k, e); end
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL %s_tx_byte %0d: got %h want %h", tag, k, b, e); end
      n_checks++; if (!stop_ok || be !== 1'b1 || ba !== 1'b0) begin
        n_fail++; $display("FAIL %s_tx_frame %0d: stop %b busy_end %b busy_after %b want 1 1 0", tag, k, stop_ok, be, ba);
      end
      if (abort_tx && k == 0) begin
        repeat (40) @(negedge clock);
        rst_n = 1'b0;
        @(posedge clock); #1;
        n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
          n_fail++; $display("FAIL %s_abort_tx: got tx %b busy %b want 1 0", tag, tx, tx_busy);
        end
        n_checks++; if (s0 !== 1'b1 || code() !== 4'd0) begin
          n_fail++; $display("FAIL %s_abort_state: got s0 %b code %0d want 1 0", tag, s0, code());
        end
        @(negedge clock);
        start_transmit = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clock);
        n_checks++; if (tx !== 1'b1 || s0 !== 1'b1) begin
          n_fail++; $display("FAIL %s_after_abort: got tx %b s0 %b want 1 1", tag, tx, s0);
        end
        return;
      end
    end
    t = 0;
    while (data_to_pc !== 1'b1 && t < 20) begin @(negedge clock); t++; end
    n_checks++; if (data_to_pc !== 1'b1 || code() !== 4'd6) begin
      n_fail++; $display("FAIL %s_tx_done: got flag %b code %0d want 1 6", tag, data_to_pc, code());
    end
    start_transmit = 1'b0;
    t = 0;
    while (s0 !== 1'b1 && t < 10) begin @(negedge clock); t++; end
    n_checks++; if (s0 !== 1'b1 || endImagereceived !== 1'b0) begin
      n_fail++; $display("FAIL %s_back_idle: got s0 %b end %b want 1 0", tag, s0, endImagereceived);
    end
  endtask

  initial begin
    test_reset();
    test_uart_rx();
    for (int i = 0; i < 64; i++) pix[i] = i;
    test_flow("ramp", 1'b0);
    for (int i = 0; i < 64; i++) pix[i] = 255;
    test_flow("ones", 1'b0);
    for (int i = 0; i < 64; i++) pix[i] = (i * 37 + 11) % 256;
    test_flow("abort", 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
